// File: rtl/rnm_adc_sampler.sv
// Real-number-model ADC front end: divided-clock sampler, saturating quantiser,
// FWFT output FIFO with sticky overflow, and a rising zero-crossing counter.
module rnm_adc_sampler #(
    parameter int  N     = 8,
    parameter real VREF  = 1.0,
    parameter int  DIV   = 4,
    parameter int  DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  real          vin,
    input  logic         en,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         ovf,
    input  logic         clr_ovf,
    output logic [15:0]  zc_count
);
    localparam int  CW    = $clog2(DIV);
    localparam int  AW    = $clog2(DEPTH);
    localparam int  HALF  = 1 << (N - 1);
    localparam real SCALE = real'(HALF) / VREF;

    logic [CW-1:0] div_q, div_d;
    logic          tick;

    real           vcap_q, vcap_d;
    logic          cap_valid_q, cap_valid_d;

    logic [N-1:0]  code_q, code_d;
    logic          code_valid_q, code_valid_d;
    real           qr;
    int            qi;
    logic [N-1:0]  code_new;

    logic [N-1:0]  prev_q, prev_d;
    logic          prev_valid_q, prev_valid_d;
    logic [15:0]   zc_q, zc_d;

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, full, accept;

    assign tick       = en && (div_q == CW'(DIV - 1));
    assign push       = code_valid_q;
    assign pop        = (cnt_q != '0) && dout_ready;
    assign full       = (cnt_q == (AW+1)'(DEPTH));
    assign accept     = push && (!full || pop);

    assign dout       = dout_q;
    assign dout_valid = (cnt_q != '0);
    assign ovf        = ovf_q;
    assign zc_count   = zc_q;

    // Round-half-up in the real domain, clamp before converting so huge
    // inputs never overflow the integer conversion.
    always_comb begin
        qr = $floor(vcap_q * SCALE + 0.5);
        if (qr > real'(HALF - 1)) begin
            qi = HALF - 1;
        end else if (qr < -real'(HALF)) begin
            qi = -HALF;
        end else begin
            qi = $rtoi(qr);
        end
        code_new = qi[N-1:0];
    end

    always_comb begin
        div_d        = '0;
        vcap_d       = vcap_q;
        cap_valid_d  = tick;
        code_d       = code_q;
        code_valid_d = cap_valid_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        zc_d         = zc_q;

        if (en && !tick) begin
            div_d = div_q + 1'b1;
        end
        if (tick) begin
            vcap_d = vin;
        end
        if (cap_valid_q) begin
            code_d       = code_new;
            prev_d       = code_new;
            prev_valid_d = 1'b1;
            if (prev_valid_q && prev_q[N-1] && !code_new[N-1]) begin
                zc_d = zc_q + 16'd1;
            end
        end
    end

    // Head is recomputed from the post-update storage so it stays FWFT and
    // simply holds when the FIFO drains.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;

        if (accept) begin
            mem_d[wr_q] = code_q;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (accept && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        dout_d = (cnt_d != '0) ? mem_d[rd_d] : dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            vcap_q       <= 0.0;
            cap_valid_q  <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            zc_q         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            div_q        <= div_d;
            vcap_q       <= vcap_d;
            cap_valid_q  <= cap_valid_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            zc_q         <= zc_d;
            mem_q        <= mem_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            ovf_q        <= ovf_d;
        end
    end
endmodule

// File: tb/tb_rnm_adc_sampler.sv
// Scoreboard bench for rnm_adc_sampler: directed vectors queue expected codes,
// an independent monitor checks every accepted output.
module tb_rnm_adc_sampler;
    localparam int  DIV = 4;
    localparam real PI  = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    real         vin = 0.0;
    logic        en = 1'b0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        ovf;
    logic        clr_ovf = 1'b0;
    logic [15:0] zc_count;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    bit          skip = 1'b0;
    logic [15:0] exp_zc = '0;
    int          m_prev = 0;
    bit          m_pv = 1'b0;

    rnm_adc_sampler #(.N(8), .VREF(1.0), .DIV(DIV), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .vin(vin), .en(en),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .ovf(ovf), .clr_ovf(clr_ovf), .zc_count(zc_count)
    );

    always #5 clk = ~clk;

    // Monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready && !skip) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %0d, queue empty",
                         $signed(dout));
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL sample: got %0d expected %0d",
                             $signed(dout), $signed(e));
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one value for one tick period; model the crossing counter.
    task automatic issue(input real v, input bit queued, input int code);
        vin = v;
        if (queued) exp_q.push_back(8'(code));
        if (m_pv && m_prev < 0 && code >= 0) exp_zc = exp_zc + 16'd1;
        m_prev = code;
        m_pv   = 1'b1;
        step(DIV);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0 && !dout_valid) break;
            step(1);
        end
        chk(name, exp_q.size() + int'(dout_valid), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_zc = '0;
        m_pv   = 1'b0;
        m_prev = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        real  qv[9]  = '{0.5, 0.25, 0.0, -0.5, 1.0, -1.0, -1.5, 0.004, -0.004};
        int   qc[9]  = '{64, 32, 0, -64, 127, -128, -128, 1, -1};
        real  ov[5]  = '{0.1, 0.2, 0.3, 0.4, 0.5};
        int   oc[5]  = '{13, 26, 38, 51, 64};
        int   zbase;

        // Reset and idle
        do_reset();
        step(3);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle", int'({dout, dout_valid, ovf, zc_count}), 0);
        end

        // Timing: en rises before E0, tick on E3, output after E5
        en = 1'b1;
        issue(0.5, 1'b1, 64);
        en = 1'b0;
        step(1);
        chk("valid_after_E4", int'(dout_valid), 0);
        step(1);
        chk("valid_after_E5", int'(dout_valid), 1);
        chk("dout_after_E5", int'($signed(dout)), 64);
        dout_ready = 1'b1;
        drain("drain_timing");

        // Quantisation
        en = 1'b1;
        for (int i = 0; i < 9; i++) issue(qv[i], 1'b1, qc[i]);
        en = 1'b0;
        drain("drain_quant");
        chk("zc_quant", int'(zc_count), int'(exp_zc));

        // Overflow
        dout_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) issue(ov[i], i < 4, oc[i]);
        en = 1'b0;
        step(2);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_head", int'($signed(dout)), 13);
        dout_ready = 1'b1;
        drain("drain_ovf");
        chk("ovf_sticky", int'(ovf), 1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_clear", int'(ovf), 0);
        chk("zc_ovf", int'(zc_count), int'(exp_zc));

        // Directed zero crossings
        en = 1'b1;
        issue(-10.0 / 128.0, 1'b1, -10);
        issue(5.0 / 128.0, 1'b1, 5);
        en = 1'b0;
        step(2);
        chk("zc_rise", int'(zc_count), int'(exp_zc));
        en = 1'b1;
        issue(-10.0 / 128.0, 1'b1, -10);
        en = 1'b0;
        step(2);
        chk("zc_fall", int'(zc_count), int'(exp_zc));
        drain("drain_zc");

        // Wrap of the crossing counter
        @(negedge clk);
        force dut.zc_q = 16'hFFFF;
        #1;
        release dut.zc_q;
        exp_zc = 16'hFFFF;
        step(1);
        en = 1'b1;
        issue(5.0 / 128.0, 1'b1, 5);
        en = 1'b0;
        step(2);
        chk("zc_wrap", int'(zc_count), int'(exp_zc));
        drain("drain_wrap");

        // Sine source, 80 clocks per period: 10 rising crossings expected
        zbase = int'(exp_zc);
        skip = 1'b1;
        en = 1'b1;
        for (int i = 40; i < 840; i++) begin
            vin = 0.8 * $sin(2.0 * PI * real'(i) / 80.0);
            step(1);
        end
        en = 1'b0;
        step(6);
        n_chk++;
        if (int'(zc_count) < zbase + 9 || int'(zc_count) > zbase + 11) begin
            n_fail++;
            $display("FAIL zc_sine: got %0d expected %0d..%0d",
                     zc_count, zbase + 9, zbase + 11);
        end
        for (int i = 0; i < 20 && dout_valid; i++) step(1);
        skip = 1'b0;

        // Reset mid-stream: 3 queued, 4th capture in flight
        dout_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 3; i++) issue(ov[i], 1'b1, oc[i]);
        vin = 0.4;
        step(DIV);
        do_reset();
        step(1);
        rst = 1'b0;
        en  = 1'b0;
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_zc", int'(zc_count), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_dout", int'(dout), 0);
        step(10);
        chk("rst_no_stale", int'(dout_valid), 0);
        dout_ready = 1'b1;
        en = 1'b1;
        issue(5.0 / 128.0, 1'b1, 5);
        en = 1'b0;
        drain("drain_post_rst");
        chk("zc_post_rst", int'(zc_count), 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rnm_adc_sampler.md
Name: rnm_adc_sampler

Overview:
- Clocked real-number-model ADC front end that sits directly downstream of the real-valued sine source.
- Samples the `real` analog net every DIV clock cycles and quantises it to a saturated N-bit two's-complement code.
- Buffers codes in a 4-entry first-word-fall-through FIFO with a valid/ready output.
- Counts rising zero crossings so the bench and downstream logic can measure source frequency.

Parameters:
- N, 8: output code width in bits (legal range 4..16).
- VREF, 1.0 (real): full-scale input magnitude; VREF maps to code 2^(N-1).
- DIV, 4: clock cycles per sample tick (legal range ≥2).
- DEPTH, 4: FIFO entries (power of two).

Ports:
- clk  input  1  sampling clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- vin  input  real  analog input; the sine source output connects here.
- en  input  1  sampling enable.
- dout  output  N  signed sample code at the FIFO head.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts dout when high together with dout_valid.
- ovf  output  1  sticky: a sample was dropped because the FIFO was full.
- clr_ovf  input  1  clears ovf.
- zc_count  output  16  count of rising zero crossings; wraps.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. rst is sampled only on the clk rising edge and has priority over all other inputs.
- Reset values: dout=0, dout_valid=0, ovf=0, zc_count=0, divider count=0, FIFO empty, capture stage invalid, previous-code register=0, prev_valid=0.
- Divider:
  - While en=0, count is forced to 0 and no ticks occur.
  - While en=1, count increments each cycle. When count==DIV-1, a tick fires and count returns to 0.
  - First tick occurs on the DIV-th rising edge with en=1.
- Stage 1 (on tick): capture vin into a real register and set cap_valid=1 for one cycle.
- Stage 2 (cycle after tick) quantises the captured value:
  - q = floor(vcap * 2^(N-1) / VREF + 0.5), computed in real arithmetic.
  - Saturate q to [-2^(N-1), 2^(N-1)-1], then convert to N-bit signed.
  - Push the result into the FIFO.
- Latency: with the FIFO empty, dout/dout_valid reflect a sample 2 cycles after its tick edge (tick edge +1 quantise, +1 FIFO write visible).
- FIFO:
  - First-word fall-through: dout is always the oldest entry. dout holds its last value when empty.
  - Pop when dout_valid && dout_ready.
  - Simultaneous push and pop while full: pop first, push accepted, no overflow.
  - Push while full with no pop: sample discarded, ovf set to 1.
  - Push and pop while empty: push is not visible until the following cycle (no bypass).
- ovf:
  - Stays set until clr_ovf=1 or rst.
  - If clr_ovf and a new overflow occur in the same cycle, ovf=1 (set wins).
- Zero crossing:
  - Evaluated on each quantised sample, independent of FIFO acceptance.
  - If prev_valid && prev_code<0 && new_code>=0, zc_count increments, wrapping 0xFFFF→0x0000.
  - Then prev_code=new_code and prev_valid=1.
  - en=0 does not clear prev_code or prev_valid.
- Reset mid-operation: in-flight capture and FIFO contents are discarded. The first post-reset sample never counts as a crossing.
- en deasserted mid-operation: a capture already taken still completes quantisation and push. Otherwise only divider behaviour changes.
- dout_ready while empty: ignored.

Test Plan:
- Reset/idle: rst high 3 cycles, then en=0 for 20 cycles -> dout=0, dout_valid=0, ovf=0, zc_count=0 throughout.
- Quantisation (N=8, VREF=1.0, DIV=4, dout_ready=1), vin held per tick:
  - 0.5 -> 64
  - 0.25 -> 32
  - 0.0 -> 0
  - -0.5 -> -64
  - 1.0 -> 127 (sat)
  - -1.0 -> -128
  - -1.5 -> -128 (sat)
  - 0.004 -> 1
  - -0.004 -> -1
- Timing: raise en at edge E0 -> tick on edge E3 (4th edge with en=1), dout_valid rises after edge E5; ticks every 4 cycles thereafter.
- Overflow: dout_ready=0, 5 ticks with vin=0.1,0.2,0.3,0.4,0.5 -> FIFO holds codes 13,26,38,51; ovf=1 after 5th push. Set dout_ready=1 -> codes pop in order. Pulse clr_ovf -> ovf=0.
- Zero crossing: drive a 1e9-Hz-period-scaled sine from the source model, ~20 samples/cycle, for 10 cycles -> zc_count=10 (±1 at start). Code sequence -10,5 -> +1; sequence 5,-10 -> no change. Force 65536 crossings -> wraps to 0.
- Reset mid-stream: assert rst with 3 entries queued and a capture in flight -> next cycle dout_valid=0, zc_count=0, ovf=0; no stale sample appears afterward.
